// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   MDOP_*   : decoded op codes driven by the funct decoder (4-bit field)
//   state_t  : mdu control state
//   md_res_t : combinational result bundle from mdu_calc
package mdu_pkg;
  localparam int MDOP_W = 4;

  localparam logic [MDOP_W-1:0] MDOP_NONE  = 4'd0;
  localparam logic [MDOP_W-1:0] MDOP_MULT  = 4'd1;
  localparam logic [MDOP_W-1:0] MDOP_MULTU = 4'd2;
  localparam logic [MDOP_W-1:0] MDOP_DIV   = 4'd3;
  localparam logic [MDOP_W-1:0] MDOP_DIVU  = 4'd4;
  localparam logic [MDOP_W-1:0] MDOP_MTHI  = 4'd5;
  localparam logic [MDOP_W-1:0] MDOP_MTLO  = 4'd6;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } md_res_t;

  // Ops that occupy the unit for multiple cycles and commit via pending regs.
  function automatic logic is_md(logic [MDOP_W-1:0] op);
    return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath.
//   mdop : decoded op (only MULT/MULTU/DIV/DIVU produce meaningful results)
//   rs   : operand A / dividend
//   rt   : operand B / divisor
//   res  : {hi, lo, div0}; div0 flags a DIV/DIVU with rt==0
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [MDOP_W-1:0] mdop,
  input  logic [31:0]       rs,
  input  logic [31:0]       rt,
  output md_res_t           res
);
  logic        sgn_mul, sgn_div;
  logic [63:0] ma, mb, prod;
  logic [31:0] a_mag, b_mag, dvs, q, r;

  always_comb begin
    sgn_mul = (mdop == MDOP_MULT);
    sgn_div = (mdop == MDOP_DIV);

    // 64-bit extension makes the low 64 bits of the product correct for both signednesses
    ma   = {{32{rs[31] & sgn_mul}}, rs};
    mb   = {{32{rt[31] & sgn_mul}}, rt};
    prod = ma * mb;

    // Signed divide on magnitudes; 0x80000000 negates to itself, which as an
    // unsigned magnitude is exactly 2^31, so the overflow case falls out naturally.
    a_mag = (sgn_div && rs[31]) ? -rs : rs;
    b_mag = (sgn_div && rt[31]) ? -rt : rt;
    dvs   = (rt == 32'd0) ? 32'd1 : b_mag;
    q     = a_mag / dvs;
    r     = a_mag % dvs;

    res      = '0;
    res.div0 = (rt == 32'd0);
    case (mdop)
      MDOP_MULT, MDOP_MULTU: begin
        res.hi   = prod[63:32];
        res.lo   = prod[31:0];
        res.div0 = 1'b0;
      end
      MDOP_DIV: begin
        res.lo = (rs[31] ^ rt[31]) ? -q : q;
        res.hi = rs[31] ? -r : r;
      end
      MDOP_DIVU: begin
        res.lo = q;
        res.hi = r;
      end
      default: res.div0 = 1'b0;
    endcase
  end
endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit with HI/LO registers.
//   clk, reset_n : clock, async active-low reset
//   start, mdop  : MD instruction valid + decoded op
//   rs, rt       : operands
//   flush        : kill in-flight op, also blocks a same-cycle start
//   busy         : op in flight (hazard unit stalls on it)
//   done         : one-cycle pulse when a MULT/DIV op commits
//   hi, lo       : architectural HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MDOP_W-1:0] mdop,
  input  logic [31:0]       rs,
  input  logic [31:0]       rt,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [31:0]       hi,
  output logic [31:0]       lo
);
  localparam int MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] M_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] D_LOAD = CW'(DIV_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  md_res_t       res, pend;
  logic          accept;

  mdu_calc u_calc (
    .mdop (mdop),
    .rs   (rs),
    .rt   (rt),
    .res  (res)
  );

  assign busy   = (state == ST_RUN);
  assign accept = start && !busy && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (mdop == MDOP_MTHI) hi <= rs;
            if (mdop == MDOP_MTLO) lo <= rs;
            if (is_md(mdop)) begin
              state <= ST_RUN;
              pend  <= res;
              cnt   <= (mdop == MDOP_MULT || mdop == MDOP_MULTU) ? M_LOAD : D_LOAD;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= '0;
          end else if (cnt == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            // divide-by-zero still completes and pulses done, but leaves HI/LO alone
            if (!pend.div0) begin
              hi <= pend.hi;
              lo <= pend.lo;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed spec cases plus randomized ops against
// a plain-arithmetic HI/LO model.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdop = 4'd0;
  logic [31:0] rs = '0, rt = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mdop(mdop), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: architectural effect of one accepted op on HI/LO.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MC;
    if (op == 4'd3 || op == 4'd4) return DC;
    return 0;
  endfunction

  // Called at a negedge: drive one op for one cycle, then wait (bounded) for busy low.
  // Returns at the negedge of the first idle cycle (the done cycle for MD ops).
  task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int cyc);
    start = 1'b1; mdop = op; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit seen;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %h want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %h want 0", done); end
    nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL rst_hi got %h want 0", hi); end
    nvec++; if (lo !== 32'd0) begin nerr++; $display("FAIL rst_lo got %h want 0", lo); end
    reset_n = 1'b1;
    @(negedge clk);
    exec(MDOP_MTHI, 32'h1234, 32'd0, cyc);
    exec(MDOP_MTLO, 32'h5678, 32'd0, cyc);
    start = 1'b1; mdop = MDOP_DIV; rs = 32'd100; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL rst_mid busy/done got %b%b want 00", busy, done);
    end
    nvec++; if (hi !== 32'd0 || lo !== 32'd0) begin
      nerr++; $display("FAIL rst_mid hi/lo got %h/%h want 0/0", hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= (done | busy);
    end
    nvec++; if (seen || hi !== 32'd0 || lo !== 32'd0) begin
      nerr++; $display("FAIL rst_nocommit got seen=%b hi=%h lo=%h want 0/0/0", seen, hi, lo);
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    int cyc;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 14; i++) begin
      if (i < 2) begin op = (i == 0) ? MDOP_MULT : MDOP_MULTU; a = 32'hFFFFFFFE; b = 32'd3; end
      else begin op = ($urandom_range(1) == 0) ? MDOP_MULT : MDOP_MULTU; a = $urandom; b = $urandom; end
      model(op, a, b);
      exec(op, a, b, cyc);
      nvec++; if (cyc !== MC) begin nerr++; $display("FAIL mult_busy[%0d] got %0d want %0d", i, cyc, MC); end
      nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL mult_done[%0d] got %b want 1", i, done); end
      nvec++; if (hi !== m_hi || lo !== m_lo) begin
        nerr++; $display("FAIL mult_res[%0d] op=%0d %h*%h got %h_%h want %h_%h", i, op, a, b, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL mult_done_pulse[%0d] got %b want 0", i, done); end
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin op = MDOP_DIV; a = -32'sd7; b = 32'd2; end
      else if (i == 1) begin op = MDOP_DIVU; a = 32'd7; b = 32'd2; end
      else begin
        op = ($urandom_range(1) == 0) ? MDOP_DIV : MDOP_DIVU;
        a = $urandom;
        case ($urandom_range(3))
          0: b = 32'd0;
          1: b = $urandom_range(9) - 32'd4;
          default: b = $urandom;
        endcase
      end
      model(op, a, b);
      exec(op, a, b, cyc);
      nvec++; if (cyc !== DC || done !== 1'b1) begin
        nerr++; $display("FAIL div_timing[%0d] got cyc=%0d done=%b want %0d/1", i, cyc, done, DC);
      end
      nvec++; if (hi !== m_hi || lo !== m_lo) begin
        nerr++; $display("FAIL div_res[%0d] op=%0d %h/%h got %h_%h want %h_%h", i, op, a, b, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_edge();
    int cyc;
    exec(MDOP_MTHI, 32'h11, 32'd0, cyc);
    exec(MDOP_MTLO, 32'h22, 32'd0, cyc);
    exec(MDOP_DIV, 32'd1234, 32'd0, cyc);
    nvec++; if (cyc !== DC || done !== 1'b1) begin
      nerr++; $display("FAIL div0_timing got cyc=%0d done=%b want %0d/1", cyc, done, DC);
    end
    nvec++; if (hi !== 32'h11 || lo !== 32'h22) begin
      nerr++; $display("FAIL div0_keep got %h/%h want 11/22", hi, lo);
    end
    exec(MDOP_DIVU, 32'hFFFF_0000, 32'd0, cyc);
    nvec++; if (hi !== 32'h11 || lo !== 32'h22) begin
      nerr++; $display("FAIL divu0_keep got %h/%h want 11/22", hi, lo);
    end
    exec(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    nvec++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      nerr++; $display("FAIL div_ovf got %h/%h want 0/80000000", hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'h8000_0000;
    @(negedge clk);
  endtask

  task automatic test_mt();
    int cyc;
    logic [3:0] op;
    exec(MDOP_MTHI, 32'hABCD, 32'd0, cyc);
    m_hi = 32'hABCD;
    nvec++; if (cyc !== 0 || done !== 1'b0 || hi !== 32'hABCD) begin
      nerr++; $display("FAIL mthi got cyc=%0d done=%b hi=%h want 0/0/abcd", cyc, done, hi);
    end
    // MTLO presented while a divide-by-zero runs must be dropped
    start = 1'b1; mdop = MDOP_DIV; rs = 32'd9; rt = 32'd0;
    @(negedge clk);
    mdop = MDOP_MTLO; rs = 32'd5;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    nvec++; if (lo !== m_lo || hi !== m_hi || cyc >= 100) begin
      nerr++; $display("FAIL mt_busy_ignored got %h/%h want %h/%h", hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      op = (i == 0) ? 4'd0 : 4'($urandom_range(15, 7));
      exec(op, $urandom, $urandom, cyc);
      nvec++; if (cyc !== 0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        nerr++; $display("FAIL none[%0d] op=%0d got cyc=%0d done=%b %h/%h want 0/0 %h/%h",
                         i, op, cyc, done, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_flush();
    bit seen;
    start = 1'b1; mdop = MDOP_MULT; rs = $urandom; rt = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL flush_busy got %b want 0", busy); end
    seen = done;
    repeat (12) begin @(negedge clk); seen |= done; end
    nvec++; if (seen || hi !== m_hi || lo !== m_lo) begin
      nerr++; $display("FAIL flush_nocommit got done=%b %h/%h want 0 %h/%h", seen, hi, lo, m_hi, m_lo);
    end
    start = 1'b1; flush = 1'b1; mdop = MDOP_MULT; rs = 32'd3; rt = 32'd4;
    @(negedge clk);
    mdop = MDOP_MTHI; rs = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    nvec++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      nerr++; $display("FAIL flush_start got busy=%b %h/%h want 0 %h/%h", busy, hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(4, 1));
      a = $urandom; b = $urandom;
      model(op, a, b);
      // each exec returns in the done cycle, so the next start lands there
      exec(op, a, b, cyc);
      nvec++; if (cyc !== lat(op) || done !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        nerr++; $display("FAIL b2b[%0d] op=%0d got cyc=%0d done=%b %h_%h want %0d/1 %h_%h",
                         i, op, cyc, done, hi, lo, lat(op), m_hi, m_lo);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_mt();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
